channelizer2_rx: RTL and testbench

CHANNELIZER2_RX -- requirements
Module: channelizer2_rx

---
 rtl/channelizer2_rx.sv | 167 ++++++++++++++++
 tb/tb_channelizer2_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/channelizer2_rx.sv
// Two-channel serial-to-parallel receiver: a packet is exactly two beats,
// channel 1 (sop) followed by channel 2 (eop). A complete pair is presented
// on out_data_1/out_data_2 with out_valid until the downstream takes it.
// Malformed framing is dropped, flagged with err_pulse and counted in a
// saturating err_count.
module channelizer2_rx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [23:0] out_data_1,
    output logic [23:0] out_data_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT1    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [23:0] r_ch1;
    logic [23:0] r_out1;
    logic [23:0] r_out2;
    logic        r_errPulse;
    logic [7:0]  r_errCount;
    logic        w_ready;
    logic        w_accept;
    logic        w_loadCh1;
    logic        w_loadOut;
    logic        w_err;

    // A beat only counts when the source offers it and we can take it.
    assign w_accept = in_valid && w_ready;

    // State register; reset abandons any partially assembled pair.
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state decode from the framing bits of each accepted beat.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_sop && !in_eop)
                        w_nextState = GOT1;
                    else if (!in_sop && !in_eop)
                        w_nextState = DISCARD;
                    else
                        w_nextState = IDLE;
                end
            end
            GOT1: begin
                if (w_accept) begin
                    case ({in_sop, in_eop})
                        2'b01:   w_nextState = HOLD;
                        2'b10:   w_nextState = GOT1;
                        2'b11:   w_nextState = IDLE;
                        default: w_nextState = DISCARD;
                    endcase
                end
            end
            HOLD: begin
                if (out_ready)
                    w_nextState = IDLE;
            end
            DISCARD: begin
                if (w_accept) begin
                    case ({in_sop, in_eop})
                        2'b01:   w_nextState = IDLE;
                        2'b10:   w_nextState = GOT1;
                        2'b11:   w_nextState = IDLE;
                        default: w_nextState = DISCARD;
                    endcase
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs plus datapath strobes and the per-beat error flag.
    always_comb begin
        w_ready   = reset_n && (r_state != HOLD);
        out_valid = (r_state == HOLD);
        w_loadCh1 = 1'b0;
        w_loadOut = 1'b0;
        w_err     = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (in_sop && !in_eop)
                        w_loadCh1 = 1'b1;
                    else
                        w_err = 1'b1;
                end
                GOT1: begin
                    case ({in_sop, in_eop})
                        2'b01:   w_loadOut = 1'b1;
                        2'b10: begin
                            w_loadCh1 = 1'b1;
                            w_err     = 1'b1;
                        end
                        default: w_err = 1'b1;
                    endcase
                end
                DISCARD: begin
                    if (in_sop && !in_eop)
                        w_loadCh1 = 1'b1;
                end
                default: begin
                    w_loadCh1 = 1'b0;
                end
            endcase
        end
    end

    assign in_ready = w_ready;

    // Channel-1 holding register and the output pair, which only moves
    // when a complete packet finishes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ch1  <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
        end else begin
            if (w_loadCh1)
                r_ch1 <= in_data;
            if (w_loadOut) begin
                r_out1 <= r_ch1;
                r_out2 <= in_data;
            end
        end
    end

    // One-cycle error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_errPulse <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_errPulse <= w_err;
            if (w_err && (r_errCount != 8'hFF))
                r_errCount <= r_errCount + 8'd1;
        end
    end

    assign out_data_1 = r_out1;
    assign out_data_2 = r_out2;
    assign err_pulse  = r_errPulse;
    assign err_count  = r_errCount;

endmodule

// File: tb/tb_channelizer2_rx.sv
// Directed self-checking bench for channelizer2_rx: a table of per-cycle
// input/expected-output records, then a saturation sequence for err_count.
module tb_channelizer2_rx;

    logic        clk;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;
    logic [23:0] out_data_1;
    logic [23:0] out_data_2;
    logic        out_valid;
    logic        out_ready;
    logic        err_pulse;
    logic [7:0]  err_count;

    int checkCount;
    int failCount;

    typedef struct {
        logic        rstN;
        logic        valid;
        logic        sop;
        logic        eop;
        logic [23:0] data;
        logic        oRdy;
        logic        expValid;
        logic [23:0] expD1;
        logic [23:0] expD2;
        logic        expPulse;
        logic [7:0]  expCount;
        logic        expReady;
    } vec_t;

    vec_t vecs[$];

    channelizer2_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic v, input logic s,
                                input logic e, input logic [23:0] d,
                                input logic o, input logic ev,
                                input logic [23:0] e1, input logic [23:0] e2,
                                input logic ep, input logic [7:0] ec,
                                input logic er);
        vec_t t;
        t.rstN = r;  t.valid = v;  t.sop = s;  t.eop = e;  t.data = d;
        t.oRdy = o;  t.expValid = ev;  t.expD1 = e1;  t.expD2 = e2;
        t.expPulse = ep;  t.expCount = ec;  t.expReady = er;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%06h, expected 0x%06h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge, then sample just after the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic s,
                                 input logic e, input logic [23:0] d,
                                 input logic o);
        @(negedge clk);
        reset_n   = r;
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = d;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int expCnt;
        checkCount = 0;
        failCount  = 0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        //               r v s e data       o   V d1        d2        P cnt R
        vecs.push_back(mk(0,0,0,0,24'h0,     0,  0,24'h0,    24'h0,    0,0,  0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h0,    24'h0,    0,0,  1));
        vecs.push_back(mk(1,1,1,0,24'h000111,1,  0,24'h0,    24'h0,    0,0,  1));
        vecs.push_back(mk(1,1,0,1,24'hFFF222,1,  1,24'h000111,24'hFFF222,0,0,0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000111,24'hFFF222,0,0,1));
        vecs.push_back(mk(1,1,0,1,24'h123456,1,  0,24'h000111,24'hFFF222,1,1,1));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000111,24'hFFF222,0,1,1));
        vecs.push_back(mk(1,1,1,0,24'h00000A,1,  0,24'h000111,24'hFFF222,0,1,1));
        vecs.push_back(mk(1,1,1,0,24'h00000B,1,  0,24'h000111,24'hFFF222,1,2,1));
        vecs.push_back(mk(1,1,0,1,24'h00000C,0,  1,24'h00000B,24'h00000C,0,2,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,1,0,24'h000777,0,1,24'h00000B,24'h00000C,0,2,0));
        vecs.push_back(mk(1,1,1,0,24'h000777,1,  0,24'h00000B,24'h00000C,0,2,1));
        vecs.push_back(mk(1,1,1,0,24'h000001,1,  0,24'h00000B,24'h00000C,0,2,1));
        vecs.push_back(mk(1,1,0,1,24'h000002,1,  1,24'h000001,24'h000002,0,2,0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000001,24'h000002,0,2,1));
        vecs.push_back(mk(1,1,1,0,24'h000005,1,  0,24'h000001,24'h000002,0,2,1));
        vecs.push_back(mk(1,1,0,0,24'h000006,1,  0,24'h000001,24'h000002,1,3,1));
        vecs.push_back(mk(1,1,0,0,24'h000007,1,  0,24'h000001,24'h000002,0,3,1));
        vecs.push_back(mk(1,1,0,1,24'h000008,1,  0,24'h000001,24'h000002,0,3,1));
        vecs.push_back(mk(1,1,1,0,24'h000010,1,  0,24'h000001,24'h000002,0,3,1));
        vecs.push_back(mk(1,1,0,0,24'h000011,1,  0,24'h000001,24'h000002,1,4,1));
        vecs.push_back(mk(1,1,1,0,24'h000020,1,  0,24'h000001,24'h000002,0,4,1));
        vecs.push_back(mk(1,1,0,1,24'h000030,1,  1,24'h000020,24'h000030,0,4,0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000020,24'h000030,0,4,1));
        vecs.push_back(mk(1,1,1,0,24'h000040,1,  0,24'h000020,24'h000030,0,4,1));
        vecs.push_back(mk(1,1,1,1,24'h000050,1,  0,24'h000020,24'h000030,1,5,1));
        vecs.push_back(mk(1,1,1,1,24'h000060,1,  0,24'h000020,24'h000030,1,6,1));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000020,24'h000030,0,6,1));
        vecs.push_back(mk(1,1,1,0,24'h000099,1,  0,24'h000020,24'h000030,0,6,1));
        vecs.push_back(mk(0,1,0,1,24'h0000AA,1,  0,24'h0,    24'h0,    0,0,  0));
        vecs.push_back(mk(1,1,0,1,24'h0000BB,1,  0,24'h0,    24'h0,    1,1,  1));
        vecs.push_back(mk(1,1,1,0,24'h000003,1,  0,24'h0,    24'h0,    0,1,  1));
        vecs.push_back(mk(1,1,0,1,24'h000004,1,  1,24'h000003,24'h000004,0,1,0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000003,24'h000004,0,1,1));
        vecs.push_back(mk(1,1,1,0,24'h000005,1,  0,24'h000003,24'h000004,0,1,1));
        vecs.push_back(mk(1,1,0,1,24'h000006,0,  1,24'h000005,24'h000006,0,1,0));
        vecs.push_back(mk(0,0,0,0,24'h0,     0,  0,24'h0,    24'h0,    0,0,  0));
        vecs.push_back(mk(1,0,1,0,24'h0,     1,  0,24'h0,    24'h0,    0,0,  1));
        vecs.push_back(mk(1,1,1,0,24'h80000D,1,  0,24'h0,    24'h0,    0,0,  1));
        vecs.push_back(mk(1,1,0,1,24'h00000E,1,  1,24'h80000D,24'h00000E,0,0,0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h80000D,24'h00000E,0,0,1));
        vecs.push_back(mk(1,1,0,0,24'h00000F,1,  0,24'h80000D,24'h00000E,1,1,1));
        vecs.push_back(mk(1,1,0,1,24'h00000F,1,  0,24'h80000D,24'h00000E,0,1,1));
        vecs.push_back(mk(1,1,1,0,24'h000100,1,  0,24'h80000D,24'h00000E,0,1,1));
        vecs.push_back(mk(1,1,0,1,24'h000200,1,  1,24'h000100,24'h000200,0,1,0));
        vecs.push_back(mk(1,0,0,0,24'h0,     1,  0,24'h000100,24'h000200,0,1,1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].valid, vecs[i].sop,
                          vecs[i].eop, vecs[i].data, vecs[i].oRdy);
            checkOutput($sformatf("v%0d out_valid", i), {23'h0, out_valid},
                        {23'h0, vecs[i].expValid});
            checkOutput($sformatf("v%0d out_data_1", i), out_data_1, vecs[i].expD1);
            checkOutput($sformatf("v%0d out_data_2", i), out_data_2, vecs[i].expD2);
            checkOutput($sformatf("v%0d err_pulse", i), {23'h0, err_pulse},
                        {23'h0, vecs[i].expPulse});
            checkOutput($sformatf("v%0d err_count", i), {16'h0, err_count},
                        {16'h0, vecs[i].expCount});
            checkOutput($sformatf("v%0d in_ready", i), {23'h0, in_ready},
                        {23'h0, vecs[i].expReady});
        end

        // 300 back-to-back orphan eops: counter climbs from 1 and sticks at 255.
        expCnt = 1;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 1'b1);
            expCnt = (expCnt < 255) ? expCnt + 1 : 255;
            checkOutput("orphan err_pulse", {23'h0, err_pulse}, 24'h1);
            checkOutput("orphan err_count", {16'h0, err_count}, expCnt[23:0]);
            checkOutput("orphan out_valid", {23'h0, out_valid}, 24'h0);
        end

        // Saturated counter still lets a clean pair through without change.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 1'b1);
        checkOutput("sat idle pulse", {23'h0, err_pulse}, 24'h0);
        checkOutput("sat count", {16'h0, err_count}, 24'hFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h654321, 1'b1);
        checkOutput("sat pair valid", {23'h0, out_valid}, 24'h1);
        checkOutput("sat pair d1", out_data_1, 24'hABCDEF);
        checkOutput("sat pair d2", out_data_2, 24'h654321);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        checkOutput("sat handoff valid", {23'h0, out_valid}, 24'h0);
        checkOutput("sat final count", {16'h0, err_count}, 24'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
